// File: rtl/sdram_port_arbiter.sv
// Shares one SDRAM controller channel between NUM_PORTS requesters.
// Define SDARB_ROUND_ROBIN_EN for round-robin arbitration (default: fixed priority).
module sdram_port_arbiter #(
    parameter int NUM_PORTS = 4,
    parameter int TIMEOUT   = 255
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NUM_PORTS-1:0]    p_req,
    input  logic [NUM_PORTS-1:0]    p_rnw,
    input  logic [NUM_PORTS*26-1:0] p_addr,
    input  logic [NUM_PORTS*32-1:0] p_din,
    output logic [31:0]             p_dout,
    output logic [NUM_PORTS-1:0]    p_ready,
    output logic [NUM_PORTS-1:0]    p_err,
    output logic                    mem_req,
    output logic                    mem_rnw,
    output logic [25:0]             mem_addr,
    output logic [31:0]             mem_din,
    input  logic [31:0]             mem_dout,
    input  logic                    mem_ready
);

    localparam int IW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 2) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [IW-1:0]   r_grant;
    logic [TW-1:0]   r_timer;
    logic [TW-1:0]   w_timer_nxt;
    logic            r_err;
    logic            r_hold;
    logic            r_mem_rnw;
    logic [25:0]     r_mem_addr;
    logic [31:0]     r_mem_din;
    logic [31:0]     r_dout;
    logic            w_found;
    logic            w_go;
    logic            w_tmo;
    logic [IW-1:0]   w_win;
    logic [NUM_PORTS-1:0] w_sel;
`ifdef SDARB_ROUND_ROBIN_EN
    logic [IW-1:0]   r_rr;
`endif

    always_comb begin
        int j;
        w_found = 1'b0;
        w_win   = '0;
        j       = 0;
        for (int k = 0; k < NUM_PORTS; k++) begin
`ifdef SDARB_ROUND_ROBIN_EN
            j = int'(r_rr) + k;
            if (j >= NUM_PORTS) j = j - NUM_PORTS;
`else
            j = k;
`endif
            if (!w_found && p_req[j]) begin
                w_found = 1'b1;
                w_win   = IW'(j);
            end
        end
    end

    // The cycle after DONE arbitrates nothing, so a stale owner level never re-wins.
    assign w_go        = w_found && !r_hold;
    assign w_timer_nxt = r_timer + 1'b1;
    assign w_tmo       = (TIMEOUT != 0) && !mem_ready
                         && (w_timer_nxt == TW'(TIMEOUT));

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:  if (w_go) w_state_nxt = S_ISSUE;
            S_ISSUE: w_state_nxt = S_WAIT;
            S_WAIT:  if (mem_ready || w_tmo) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_grant    <= '0;
            r_timer    <= '0;
            r_err      <= 1'b0;
            r_hold     <= 1'b0;
            r_mem_rnw  <= 1'b0;
            r_mem_addr <= '0;
            r_mem_din  <= '0;
            r_dout     <= '0;
`ifdef SDARB_ROUND_ROBIN_EN
            r_rr       <= '0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_hold  <= (r_state == S_DONE);
            unique case (r_state)
                S_IDLE: begin
                    if (w_go) begin
                        r_grant    <= w_win;
                        r_err      <= 1'b0;
                        r_mem_rnw  <= p_rnw[w_win];
                        r_mem_addr <= p_addr[26*w_win +: 26];
                        r_mem_din  <= p_din[32*w_win +: 32];
                    end
                end
                S_ISSUE: r_timer <= '0;
                S_WAIT: begin
                    r_timer <= w_timer_nxt;
                    if (mem_ready) begin
                        if (r_mem_rnw) r_dout <= mem_dout;
                    end else if (w_tmo) begin
                        r_err  <= 1'b1;
                        r_dout <= '0;
                    end
                end
                S_DONE: begin
`ifdef SDARB_ROUND_ROBIN_EN
                    if (r_grant == IW'(NUM_PORTS - 1)) r_rr <= '0;
                    else r_rr <= r_grant + 1'b1;
`endif
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_sel          = '0;
        w_sel[r_grant] = 1'b1;
    end

    assign mem_req  = (r_state == S_ISSUE);
    assign mem_rnw  = r_mem_rnw;
    assign mem_addr = r_mem_addr;
    assign mem_din  = r_mem_din;
    assign p_dout   = r_dout;
    assign p_ready  = (r_state == S_DONE) ? w_sel : '0;
    assign p_err    = p_ready & {NUM_PORTS{r_err}};

endmodule
